ex_pipe_ctrl: RTL and testbench
===============================

Name: ex_pipe_ctrl

Overview:
Pipeline sequencing controller for the EX stage of the RISC-V lite core. It generates the per-stage register enables (including the EX/MEM `regEn`), bubble and flush strobes. It resolves three conditions in priority order: taken-branch flush, multi-cycle ALU freeze and load-use stall. It also keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- MC_LAT, 4, total EX occupancy in cycles of a multi-cycle ALU op; must be >=1; a value of 1 disables freezing.
- CNT_W, 16, width of stall_count.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID stage holds a valid instruction.
- id_rs1  in  5  ID source register 1.
- id_rs2  in  5  ID source register 2.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_rd  in  5  EX destination register.
- ex_mem_read  in  1  EX instruction is a load.
- ex_multicycle  in  1  EX instruction is a multi-cycle ALU op.
- branch_taken  in  1  branch resolved taken at the EX/MEM register output.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID register enable.
- idex_en  out  1  ID/EX register enable.
- exmem_en  out  1  EX/MEM register enable; drives execute `regEn`.
- idex_bubble  out  1  load NOP control into ID/EX.
- ifid_flush  out  1  invalidate IF/ID.
- idex_flush  out  1  invalidate ID/EX.
- exmem_bubble  out  1  clear valid/control bits of the EX/MEM entry.
- busy  out  1  state is MC_WAIT.
- stall_count  out  CNT_W  saturating count of cycles with pc_en=0.

Behaviour:
- Single clock domain. Reset is synchronous active-high. On reset: state=RUN, mc_cnt=0, stall_count=0.
- While rst=1, all enables=0, all flush/bubble=0, busy=0.
- Outputs are combinational from the registered state plus current inputs. State, mc_cnt and stall_count are registered.
- load_use = ex_valid & ex_mem_read & (ex_rd!=0) & id_valid & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- mc_start = ex_valid & ex_multicycle & (MC_LAT>1).
- Default (RUN, no event): all four enables=1, all flush/bubble=0.
- States: RUN, MC_WAIT.
- Priority 1, branch_taken (any state):
  - pc_en=ifid_en=idex_en=exmem_en=1.
  - ifid_flush=idex_flush=exmem_bubble=1.
  - Next state=RUN, mc_cnt=0. This aborts any multi-cycle op in progress.
- Priority 2, RUN & mc_start:
  - All enables=0 (freeze).
  - mc_cnt<=MC_LAT-1, next state=MC_WAIT.
- Priority 3, RUN & load_use:
  - pc_en=ifid_en=0; idex_en=1 with idex_bubble=1; exmem_en=1.
  - Lasts one cycle and stays in RUN. The hazard clears because the load advances to MEM.
- MC_WAIT with mc_cnt>1: all enables=0, mc_cnt decrements.
- MC_WAIT with mc_cnt==1 (release cycle):
  - All enables=1; load_use is not evaluated because EX holds the MC op.
  - Next state=RUN, mc_cnt=0.
- Total EX occupancy of an MC op is exactly MC_LAT cycles; the ALU result is captured at the end of the last cycle.
- Freeze has priority over load_use when both are true. load_use is re-evaluated naturally after release.
- stall_count increments in every non-reset cycle with pc_en=0 and holds at 2^CNT_W-1.
- Reset in MC_WAIT returns to RUN on the next edge with mc_cnt=0.
- ex_rd=0 never triggers a load-use stall.

Test Plan:
1. Reset for 2 cycles, then idle valid traffic -> all enables=1, flush/bubble=0, busy=0, stall_count=0.
2. Load-use: ex_valid=1, ex_mem_read=1, ex_rd=5, id_valid=1, id_use_rs2=1, id_rs2=5 -> exactly one cycle with pc_en=ifid_en=0, idex_bubble=1, exmem_en=1. stall_count=1. Repeat with ex_rd=0 -> no stall.
3. Multi-cycle op with MC_LAT=4 -> enables=0 for 3 cycles with busy=1 in cycles 2-3. Enables=1 in cycle 4, then RUN. stall_count increases by 3.
4. MC op and load_use true in the same cycle -> freeze behaviour only, with idex_bubble=0 throughout.
5. branch_taken in the 2nd MC_WAIT cycle -> same cycle ifid_flush=idex_flush=exmem_bubble=1, all enables=1, busy=0 next cycle. Separately, branch_taken with load_use -> flush wins, idex_bubble=0.
6. CNT_W=4 with 20 consecutive freeze cycles -> stall_count saturates at 15. A synchronous rst asserted mid-MC_WAIT -> RUN with stall_count=0 after the edge.

Source files
------------

// File: rtl/ex_pipe_ctrl.sv
// EX-stage pipeline sequencing controller: register enables, bubble and flush strobes
// for branch flush, multi-cycle ALU freeze and load-use stall, plus a stall-cycle counter.
module ex_pipe_ctrl #(
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_valid,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_multicycle,
    input  logic             branch_taken,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_bubble,
    output logic             busy,
    output logic [CNT_W-1:0] stall_count
);

    localparam int MC_W = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
    localparam logic [MC_W-1:0]  MC_LOAD = MC_W'(MC_LAT - 1);
    localparam logic             MC_EN   = (MC_LAT > 1) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [MC_W-1:0]  mc_cnt_r;
    logic [MC_W-1:0]  mc_cnt_nxt_s;
    logic [CNT_W-1:0] stall_count_r;
    logic             load_use_s;
    logic             mc_start_s;

    // Hazard detection; a write to x0 never creates a dependency.
    always_comb begin
        load_use_s = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
        mc_start_s = ex_valid & ex_multicycle & MC_EN;
    end

    // Resolve flush > freeze > load-use and derive strobes and next state.
    always_comb begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        exmem_en     = 1'b0;
        idex_bubble  = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_bubble = 1'b0;
        state_nxt_s  = state_r;
        mc_cnt_nxt_s = mc_cnt_r;
        if (rst) begin
            state_nxt_s  = RUN;
            mc_cnt_nxt_s = {MC_W{1'b0}};
        end else if (branch_taken) begin
            pc_en        = 1'b1;
            ifid_en      = 1'b1;
            idex_en      = 1'b1;
            exmem_en     = 1'b1;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            exmem_bubble = 1'b1;
            state_nxt_s  = RUN;
            mc_cnt_nxt_s = {MC_W{1'b0}};
        end else begin
            case (state_r)
                RUN: begin
                    if (mc_start_s) begin
                        state_nxt_s  = MC_WAIT;
                        mc_cnt_nxt_s = MC_LOAD;
                    end else if (load_use_s) begin
                        idex_en     = 1'b1;
                        idex_bubble = 1'b1;
                        exmem_en    = 1'b1;
                    end else begin
                        pc_en    = 1'b1;
                        ifid_en  = 1'b1;
                        idex_en  = 1'b1;
                        exmem_en = 1'b1;
                    end
                end
                MC_WAIT: begin
                    // EX still holds the MC op here, so load-use is not considered.
                    if (mc_cnt_r > MC_W'(1'b1)) begin
                        mc_cnt_nxt_s = mc_cnt_r - MC_W'(1'b1);
                    end else begin
                        pc_en        = 1'b1;
                        ifid_en      = 1'b1;
                        idex_en      = 1'b1;
                        exmem_en     = 1'b1;
                        state_nxt_s  = RUN;
                        mc_cnt_nxt_s = {MC_W{1'b0}};
                    end
                end
                default: begin
                    state_nxt_s  = RUN;
                    mc_cnt_nxt_s = {MC_W{1'b0}};
                end
            endcase
        end
    end

    // State, latency counter and saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= RUN;
            mc_cnt_r      <= {MC_W{1'b0}};
            stall_count_r <= {CNT_W{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            mc_cnt_r <= mc_cnt_nxt_s;
            if (!pc_en && (stall_count_r != CNT_MAX)) begin
                stall_count_r <= stall_count_r + CNT_W'(1'b1);
            end else begin
                stall_count_r <= stall_count_r;
            end
        end
    end

    // Busy flag is suppressed while reset is held.
    always_comb begin
        if (rst) begin
            busy = 1'b0;
        end else begin
            busy = (state_r == MC_WAIT) ? 1'b1 : 1'b0;
        end
        stall_count = stall_count_r;
    end

endmodule

// File: tb/tb_ex_pipe_ctrl.sv
// Scoreboard bench for ex_pipe_ctrl: directed vectors push expectations, a negedge
// monitor pops and compares. A second instance (MC_LAT=21, CNT_W=4) covers saturation.
module tb_ex_pipe_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, id_valid, id_use_rs1, id_use_rs2, ex_valid, ex_mem_read, ex_multicycle, branch_taken;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       pc_en, ifid_en, idex_en, exmem_en, idex_bubble, ifid_flush, idex_flush, exmem_bubble, busy;
    logic [15:0] stall_count;

    logic       s_rst, s_ex_valid, s_ex_multicycle;
    logic       s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_idex_bubble, s_ifid_flush, s_idex_flush;
    logic       s_exmem_bubble, s_busy;
    logic [3:0] s_stall_count;
    logic       zero1;
    logic [4:0] zero5;

    ex_pipe_ctrl #(.MC_LAT(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_valid(ex_valid), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_multicycle(ex_multicycle), .branch_taken(branch_taken),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .idex_bubble(idex_bubble), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_bubble(exmem_bubble), .busy(busy), .stall_count(stall_count)
    );

    ex_pipe_ctrl #(.MC_LAT(21), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(s_rst), .id_valid(zero1), .id_rs1(zero5), .id_rs2(zero5),
        .id_use_rs1(zero1), .id_use_rs2(zero1), .ex_valid(s_ex_valid), .ex_rd(zero5),
        .ex_mem_read(zero1), .ex_multicycle(s_ex_multicycle), .branch_taken(zero1),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en), .exmem_en(s_exmem_en),
        .idex_bubble(s_idex_bubble), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
        .exmem_bubble(s_exmem_bubble), .busy(s_busy), .stall_count(s_stall_count)
    );

    // {pc_en, ifid_en, idex_en, exmem_en, idex_bubble, ifid_flush, idex_flush, exmem_bubble, busy}
    localparam logic [8:0] V_RESET  = 9'b0000_0000_0;
    localparam logic [8:0] V_IDLE   = 9'b1111_0000_0;
    localparam logic [8:0] V_FRZ_R  = 9'b0000_0000_0;
    localparam logic [8:0] V_FRZ_W  = 9'b0000_0000_1;
    localparam logic [8:0] V_REL    = 9'b1111_0000_1;
    localparam logic [8:0] V_LU     = 9'b0011_1000_0;
    localparam logic [8:0] V_FLSH_W = 9'b1111_0111_1;
    localparam logic [8:0] V_FLSH_R = 9'b1111_0111_0;

    typedef struct {
        string       name;
        logic [8:0]  vec;
        logic [15:0] cnt;
        logic        sbusy;
        logic [3:0]  scnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;
    logic [8:0] act_vec;

    // Monitor: compare every cycle's outputs against the oldest expectation.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            act_vec = {pc_en, ifid_en, idex_en, exmem_en, idex_bubble, ifid_flush, idex_flush,
                       exmem_bubble, busy};
            checks = checks + 3;
            if (act_vec !== e.vec) begin
                failures = failures + 1;
                $display("FAIL %s ctrl: actual=%b required=%b", e.name, act_vec, e.vec);
            end
            if (stall_count !== e.cnt) begin
                failures = failures + 1;
                $display("FAIL %s stall_count: actual=%0d required=%0d", e.name, stall_count, e.cnt);
            end
            if ({s_busy, s_stall_count} !== {e.sbusy, e.scnt}) begin
                failures = failures + 1;
                $display("FAIL %s sat busy/count: actual=%b/%0d required=%b/%0d",
                         e.name, s_busy, s_stall_count, e.sbusy, e.scnt);
            end
        end
    end

    task automatic step(input string name, input logic [8:0] vec, input logic [15:0] cnt,
                        input logic sbusy = 1'b0, input logic [3:0] scnt = 4'd0);
        exp_t x;
        x.name = name; x.vec = vec; x.cnt = cnt; x.sbusy = sbusy; x.scnt = scnt;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_valid = 1'b1; id_rs1 = 5'd1; id_rs2 = 5'd2; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
        ex_valid = 1'b1; ex_rd = 5'd3; ex_mem_read = 1'b0; ex_multicycle = 1'b0; branch_taken = 1'b0;
    endtask

    initial begin
        zero1 = 1'b0; zero5 = 5'd0;
        s_rst = 1'b1; s_ex_valid = 1'b0; s_ex_multicycle = 1'b0;
        rst = 1'b1;
        set_idle();
        @(posedge clk);
        #1;
        // Reset and idle traffic
        step("reset0", V_RESET, 16'd0);
        step("reset1", V_RESET, 16'd0);
        rst = 1'b0;
        step("idle", V_IDLE, 16'd0);
        ex_mem_read = 1'b1;
        step("load_nomatch", V_IDLE, 16'd0);
        // Load-use on rs2, then hazard clears
        id_use_rs1 = 1'b0; ex_rd = 5'd5; id_rs2 = 5'd5;
        step("lu_rs2", V_LU, 16'd0);
        ex_mem_read = 1'b0; ex_rd = 5'd7;
        step("lu_clear", V_IDLE, 16'd1);
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0;
        step("lu_x0", V_IDLE, 16'd1);
        id_use_rs1 = 1'b1; id_rs1 = 5'd9; ex_rd = 5'd9; id_rs2 = 5'd2;
        step("lu_rs1", V_LU, 16'd1);
        ex_mem_read = 1'b0; ex_rd = 5'd3;
        step("lu_rs1_clear", V_IDLE, 16'd2);
        id_use_rs1 = 1'b0; ex_mem_read = 1'b1; ex_rd = 5'd9;
        step("lu_unused_rs1", V_IDLE, 16'd2);
        // Multi-cycle op
        set_idle(); ex_multicycle = 1'b1;
        step("mc_c1", V_FRZ_R, 16'd2);
        step("mc_c2", V_FRZ_W, 16'd3);
        step("mc_c3", V_FRZ_W, 16'd4);
        step("mc_c4_rel", V_REL, 16'd5);
        ex_multicycle = 1'b0;
        step("mc_after", V_IDLE, 16'd5);
        // MC op with simultaneous load-use
        ex_multicycle = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5;
        step("mclu_c1", V_FRZ_R, 16'd5);
        step("mclu_c2", V_FRZ_W, 16'd6);
        step("mclu_c3", V_FRZ_W, 16'd7);
        step("mclu_rel", V_REL, 16'd8);
        set_idle();
        step("mclu_after", V_IDLE, 16'd8);
        // Branch during MC_WAIT, then branch vs load-use and vs mc_start
        ex_multicycle = 1'b1;
        step("br_mc_c1", V_FRZ_R, 16'd8);
        step("br_mc_c2", V_FRZ_W, 16'd9);
        branch_taken = 1'b1;
        step("br_mc_flush", V_FLSH_W, 16'd10);
        branch_taken = 1'b0; ex_multicycle = 1'b0;
        step("br_mc_after", V_IDLE, 16'd10);
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; branch_taken = 1'b1;
        step("br_lu", V_FLSH_R, 16'd10);
        set_idle();
        step("br_lu_after", V_IDLE, 16'd10);
        ex_multicycle = 1'b1; branch_taken = 1'b1;
        step("br_mcstart", V_FLSH_R, 16'd10);
        set_idle();
        step("br_mcstart_after", V_IDLE, 16'd10);
        // Saturation on the CNT_W=4 instance: 20 consecutive freeze cycles
        s_rst = 1'b0; s_ex_valid = 1'b1; s_ex_multicycle = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            if (k == 22) s_ex_multicycle = 1'b0;
            step("sat", V_IDLE, 16'd10, (k >= 2 && k <= 21), (k > 16) ? 4'd15 : 4'(k - 1));
        end
        // Synchronous reset in MC_WAIT
        ex_multicycle = 1'b1;
        step("rst_mc_c1", V_FRZ_R, 16'd10, 1'b0, 4'd15);
        step("rst_mc_c2", V_FRZ_W, 16'd11, 1'b0, 4'd15);
        rst = 1'b1;
        step("rst_mc_hold", V_RESET, 16'd12, 1'b0, 4'd15);
        rst = 1'b0; ex_multicycle = 1'b0;
        step("rst_mc_after", V_IDLE, 16'd0, 1'b0, 4'd15);
        ex_valid = 1'b0; ex_multicycle = 1'b1;
        step("mc_not_valid", V_IDLE, 16'd0, 1'b0, 4'd15);
        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL drain: actual=%0d pending required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
